// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with first-word fall-through output, registered-count
// status flags and sticky overflow/underflow error flags.
module sync_fifo_flags #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_SIZE   = 5,
  parameter int AF_THRESH  = 28,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [PTR_SIZE:0]     count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_SIZE:0] DEPTH_C = (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0] AF_C    = (PTR_SIZE+1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0] AE_C    = (PTR_SIZE+1)'(AE_THRESH);
  localparam logic [PTR_SIZE:0] ONE_C   = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE-1:0] PINC  = PTR_SIZE'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]     count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  rd_acc, wr_acc;

  // Status flags decode the registered count only, so they lag the access by one edge.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == DEPTH_C);
    almost_empty = (count_q <= AE_C);
    almost_full  = (count_q >= AF_C);
    count        = count_q;
    overflow     = ovf_q;
    underflow    = udf_q;
    data_out     = empty ? '0 : mem_q[rd_ptr_q];
  end

  // Accept decode and next state; a full FIFO takes a write only alongside a pop.
  always_comb begin
    rd_acc   = re_en && !empty;
    wr_acc   = wr_en && (!full || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q && !clr_err;
    udf_d    = udf_q && !clr_err;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PINC;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PINC;
      if (wr_acc && !rd_acc) count_d = count_q + ONE_C;
      if (rd_acc && !wr_acc) count_d = count_q - ONE_C;
      // a new error event beats a coincident clear
      if (wr_en && !wr_acc) ovf_d = 1'b1;
      if (re_en && empty)   udf_d = 1'b1;
    end
  end

  // Pointer, count and sticky flag state; reset outranks flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array is never reset; only accepted writes outside rst/flush land.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_sync_fifo_flags;
  localparam int DEPTH = 8, DW = 8, PS = 3, AF = 6, AE = 2;

  logic clk = 1'b0;
  logic rst, flush, clr_err, wr_en, re_en;
  logic [DW-1:0] data_in, data_out;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic [PS:0] count;

  sync_fifo_flags #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PTR_SIZE(PS),
                    .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .wr_en(wr_en), .data_in(data_in), .re_en(re_en), .data_out(data_out),
    .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;

  // reference model: contents as a queue, sticky flags as bits
  logic [DW-1:0] mq[$];
  bit m_ovf, m_udf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int n;
    bit rd, wr;
    n = mq.size();
    if (rst) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
    end else if (flush) begin
      mq.delete();
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
    end else begin
      rd = re_en && n > 0;
      wr = wr_en && (n < DEPTH || rd);
      if (clr_err) begin m_ovf = 0; m_udf = 0; end
      if (wr_en && !wr) m_ovf = 1;
      if (re_en && n == 0) m_udf = 1;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(data_in);
    end
  endtask

  // every-cycle compare of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= AE));
      chk("almost_full", 32'(almost_full), 32'(mq.size() >= AF));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_udf));
      chk("data_out", 32'(data_out), mq.size() == 0 ? 32'h0 : 32'(mq[0]));
    end
  end

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
    wr_en = w; data_in = d; re_en = r; flush = f; clr_err = c; rst = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [DW-1:0] exp_out [9];
  logic [DW-1:0] sent[$];
  logic [DW-1:0] got[$];

  initial begin
    rst = 1; flush = 0; clr_err = 0; wr_en = 0; re_en = 0; data_in = '0;
    step(0, 8'h00, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk_en = 1'b1;
    // reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(data_out), 0);

    // fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      step(1, 8'(i), 0);
      chk("fill_count", 32'(count), 32'(i));
      if (i == 2) chk("ae_at2", 32'(almost_empty), 1);
      if (i == 3) chk("ae_at3", 32'(almost_empty), 0);
      if (i == 5) chk("af_at5", 32'(almost_full), 0);
      if (i == 6) chk("af_at6", 32'(almost_full), 1);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);
    chk("fill_head", 32'(data_out), 32'h01);

    // rejected write when full, then write+read when full
    step(1, 8'h99, 0);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_set", 32'(overflow), 1);
    step(1, 8'hAA, 1);
    chk("wr_rd_full_count", 32'(count), 8);
    chk("wr_rd_full_head", 32'(data_out), 32'h02);

    // drain; order 02..08 then AA
    exp_out = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(data_out), 32'(exp_out[i]));
      step(0, 8'h00, 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_udf", 32'(underflow), 0);

    // underflow, and set beats clear
    step(0, 8'h00, 1);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_count", 32'(count), 0);
    chk("udf_dout", 32'(data_out), 0);
    step(0, 8'h00, 1, 0, 1);
    chk("udf_set_wins", 32'(underflow), 1);
    chk("ovf_cleared", 32'(overflow), 0);

    // flush at count 5 with write; sticky underflow survives
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0);
    chk("pre_flush_count", 32'(count), 5);
    step(1, 8'h55, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_udf_kept", 32'(underflow), 1);
    step(0, 8'h00, 1, 1);
    chk("flush_no_udf_effect", 32'(underflow), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_udf", 32'(underflow), 0);

    // 20 words across pointer wraps with random simultaneous access
    begin
      int n_sent = 0, cyc = 0;
      bit w, r;
      logic [DW-1:0] d;
      sent.delete(); got.delete();
      while ((n_sent < 20 || mq.size() > 0) && cyc < 400) begin
        w = (n_sent < 20) && ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 2) != 0);
        d = 8'($urandom);
        if (r && mq.size() > 0) got.push_back(data_out);
        if (w && (mq.size() < DEPTH || (r && mq.size() > 0))) begin
          sent.push_back(d); n_sent++;
        end
        step(w, d, r);
        cyc++;
      end
      chk("rand_done", 32'(cyc < 400), 1);
      chk("rand_len", 32'(got.size()), 32'(sent.size()));
      for (int i = 0; i < sent.size() && i < got.size(); i++)
        chk("rand_order", 32'(got[i]), 32'(sent[i]));
    end
    step(0, 8'h00, 0, 0, 1);

    // reset mid-operation at count 7 with overflow set
    for (int i = 0; i < 8; i++) step(1, 8'(8'h60 + i), 0);
    step(1, 8'hEE, 0);
    step(0, 8'h00, 1);
    chk("pre_rst_count", 32'(count), 7);
    chk("pre_rst_ovf", 32'(overflow), 1);
    step(1, 8'h77, 1, 0, 0, 1);
    chk("rst_mid_count", 32'(count), 0);
    chk("rst_mid_empty", 32'(empty), 1);
    chk("rst_mid_ovf", 32'(overflow), 0);
    chk("rst_mid_udf", 32'(underflow), 0);
    chk("rst_mid_dout", 32'(data_out), 0);
    step(0, 8'h00, 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, number of entries; power of two, minimum 2.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8, data bus width in bits.
REQ-003 SHALL provide parameter PTR_SIZE, default 5, pointer width; equals log2(DEPTH).
REQ-004 SHALL provide parameter AF_THRESH, default 28, almost-full level; range 1..DEPTH.
REQ-005 SHALL provide parameter AE_THRESH, default 4, almost-empty level; range 0..DEPTH-1.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 flush  input  1  synchronous discard of all stored entries.
REQ-009 clr_err  input  1  clears sticky error flags.
REQ-010 wr_en  input  1  write request.
REQ-011 data_in  input  DATA_WIDTH  write data.
REQ-012 re_en  input  1  read request; pops the current head.
REQ-013 data_out  output  DATA_WIDTH  head entry (first-word fall-through).
REQ-014 empty  output  1  count == 0.
REQ-015 full  output  1  count == DEPTH.
REQ-016 almost_empty  output  1  count <= AE_THRESH.
REQ-017 almost_full  output  1  count >= AF_THRESH.
REQ-018 count  output  PTR_SIZE+1  number of stored entries, 0..DEPTH.
REQ-019 overflow  output  1  sticky: a write was rejected.
REQ-020 underflow  output  1  sticky: a read was rejected.

Function
REQ-021 Read accept (rd_acc) SHALL be re_en && !empty; no bypass of same-cycle write data to an empty FIFO.
REQ-022 Write accept (wr_acc) SHALL be wr_en && (!full || rd_acc); writing when full is accepted only with a simultaneous accepted read.
REQ-023 On wr_acc, data_in SHALL be stored at wr_ptr and wr_ptr SHALL increment modulo DEPTH.
REQ-024 On rd_acc, rd_ptr SHALL increment modulo DEPTH; the popped word is data_out in that cycle.
REQ-025 count SHALL be +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
REQ-026 empty, full, almost_empty, almost_full SHALL be decoded from the registered count only; they change on the clock edge after the causing access.
REQ-027 data_out SHALL be memory[rd_ptr] when !empty and all-zeros when empty; never X/Z after reset.
REQ-028 overflow SHALL set on the edge after wr_en && !wr_acc; underflow SHALL set on the edge after re_en && empty.
REQ-029 Sticky flags SHALL hold until clr_err or rst; if set and clear coincide, set SHALL win.
REQ-030 flush SHALL zero wr_ptr, rd_ptr, count on the next edge, overriding wr_en/re_en that cycle; it SHALL NOT alter overflow/underflow.
REQ-031 Accesses during flush SHALL NOT set overflow or underflow.
REQ-032 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order SHALL be strictly preserved across wraps.
REQ-033 Memory contents SHALL NOT be reset; only pointers, count and flags.
REQ-034 Priority per edge SHALL be rst > flush > normal access.

Reset
REQ-035 On rst at a clock edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0.
REQ-036 After reset outputs SHALL be: empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>=1), data_out=0.
REQ-037 rst asserted mid-operation SHALL discard all content within one edge regardless of wr_en/re_en.

Verification (DEPTH=8, DATA_WIDTH=8, PTR_SIZE=3, AF_THRESH=6, AE_THRESH=2)
REQ-038 Write 0x01..0x08 on 8 consecutive cycles -> count 1..8; almost_empty drops at count 3; almost_full rises at count 6; full=1 at count 8; overflow=0.
REQ-039 Full, wr_en=1 alone with 0x99 -> count stays 8, overflow=1 next edge; then wr_en=1, re_en=1 with 0xAA -> 0x01 popped, count stays 8, 0xAA last out.
REQ-040 Empty, re_en=1 -> underflow=1, count 0, data_out 0x00; clr_err=1 with re_en=1 same cycle -> underflow stays 1.
REQ-041 Fill/drain 20 words across wraps with random simultaneous access -> output sequence equals input sequence; count always matches scoreboard.
REQ-042 count=5 and flush=1 with wr_en=1 -> next edge count=0, empty=1, no overflow; sticky flags previously set remain set.
REQ-043 rst=1 at count=7 with wr_en=1, re_en=1 -> next edge count=0, empty=1, overflow=0, underflow=0, data_out=0x00.
